// File: rtl/display.sv
// Eight-digit multiplexed hex seven-segment driver (common anode, active-low lines).
// Define DISPLAY_LEADING_ZERO_BLANK_EN to darken leading-zero digits above digit 0.
module display #(
    parameter int CLK_DIV = 50_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reset_2,
    input  logic [31:0] number,
    input  logic [7:0]  AN_ON,
    output logic [7:0]  AN,
    output logic [6:0]  sevenSeg
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic          run;
    logic [3:0]    nib;
    logic [6:0]    seg_dec;
    logic          lit;

    // run is low on the first edge after a restart so digit 0 gets a full CLK_DIV slot
    always_comb begin
        cnt_nxt = cnt;
        idx_nxt = idx;
        if (!run) begin
            cnt_nxt = '0;
        end else if (cnt == LAST) begin
            cnt_nxt = '0;
            idx_nxt = idx + 3'd1;
        end else begin
            cnt_nxt = cnt + CW'(1);
        end

        nib = number[{idx_nxt, 2'b00} +: 4];
        lit = AN_ON[idx_nxt];
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        if ((idx_nxt != 3'd0) && ((number >> {idx_nxt, 2'b00}) == 32'd0))
            lit = 1'b0;
`endif

        case (nib)
            4'h0: seg_dec = 7'h40;
            4'h1: seg_dec = 7'h79;
            4'h2: seg_dec = 7'h24;
            4'h3: seg_dec = 7'h30;
            4'h4: seg_dec = 7'h19;
            4'h5: seg_dec = 7'h12;
            4'h6: seg_dec = 7'h02;
            4'h7: seg_dec = 7'h78;
            4'h8: seg_dec = 7'h00;
            4'h9: seg_dec = 7'h10;
            4'hA: seg_dec = 7'h08;
            4'hB: seg_dec = 7'h03;
            4'hC: seg_dec = 7'h46;
            4'hD: seg_dec = 7'h21;
            4'hE: seg_dec = 7'h06;
            default: seg_dec = 7'h0E;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            idx      <= 3'd0;
            run      <= 1'b0;
            AN       <= 8'hFF;
            sevenSeg <= 7'h7F;
        end else if (reset_2) begin
            cnt      <= '0;
            idx      <= 3'd0;
            run      <= 1'b0;
            AN       <= 8'hFF;
            sevenSeg <= 7'h7F;
        end else begin
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            run      <= 1'b1;
            AN       <= lit ? ~(8'h01 << idx_nxt) : 8'hFF;
            sevenSeg <= lit ? seg_dec : 7'h7F;
        end
    end

endmodule

// File: tb/tb_display.sv
// Randomized and directed bench for display, checked against a time-slot reference model.
module tb_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset_2 = 1'b1;
    logic [31:0] number = 32'h0;
    logic [7:0]  AN_ON = 8'h0;
    logic [7:0]  AN;
    logic [6:0]  sevenSeg;

    int n_chk = 0;
    int n_err = 0;

    display #(.CLK_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .reset_2(reset_2),
        .number(number), .AN_ON(AN_ON), .AN(AN), .sevenSeg(sevenSeg)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Expected {AN, seg} for digit slot d given the live inputs
    function automatic logic [14:0] ref_out(input int d, input logic [31:0] num, input logic [7:0] msk);
        logic [31:0] upper;
        int          n;
        bit          show;
        upper = num >> (4 * d);
        n     = int'(upper & 32'hF);
        show  = msk[d];
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        if (d != 0 && upper == 0) show = 0;
`endif
        if (show) return {~(8'h01 << d), SEG[n]};
        return {8'hFF, 7'h7F};
    endfunction

    // t counts edges since the last restart; each slot is DIV edges long
    int          t;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;

    always @(posedge clk or negedge reset) begin
        if (!reset || reset_2) begin
            t       <= 0;
            exp_an  <= 8'hFF;
            exp_seg <= 7'h7F;
        end else begin
            {exp_an, exp_seg} <= ref_out((t / DIV) % 8, number, AN_ON);
            t <= t + 1;
        end
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        chk({tag, "_an"}, AN, exp_an);
        chk({tag, "_seg"}, {1'b0, sevenSeg}, {1'b0, exp_seg});
    endtask

    logic [7:0] t2_an  [8] = '{8'hFF, 8'hFF, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hFF, 8'hFF};
    logic [6:0] t2_seg [8] = '{7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F};

    initial begin
        // async reset with no clock edge yet
        number = $urandom;
        AN_ON  = $urandom;
        #1 reset = 1'b0;
        #2;
        chk("rst_an", AN, 8'hFF);
        chk("rst_seg", {1'b0, sevenSeg}, 8'h7F);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step("hold_r2");
            chk("hold_an_const", AN, 8'hFF);
        end

        // masked scan, constant expectations over two frames
        number  = 32'h24000042;
        AN_ON   = 8'b0011_1100;
        reset_2 = 1'b0;
        for (int f = 0; f < 2; f++)
            for (int d = 0; d < 8; d++)
                for (int c = 0; c < DIV; c++) begin
                    @(negedge clk);
                    chk("mask_an", AN, t2_an[d]);
                    chk("mask_seg", {1'b0, sevenSeg}, {1'b0, t2_seg[d]});
                end

        // full decode of both values
        AN_ON = 8'hFF;
        reset_2 = 1'b1;
        step("dec_r2");
        reset_2 = 1'b0;
        number = 32'h01234567;
        for (int i = 0; i < 8 * DIV; i++) step("dec_a");
        number = 32'h89ABCDEF;
        for (int i = 0; i < 8 * DIV; i++) step("dec_b");

        // reset_2 pulse while digit 5 is lit
        for (int i = 0; i < 5 * DIV + 1; i++) step("pre5");
        chk("d5_an", AN, 8'hDF);
        reset_2 = 1'b1;
        step("r2_pulse");
        chk("r2_dark", AN, 8'hFF);
        reset_2 = 1'b0;
        step("r2_rel");
        chk("r2_d0_an", AN, 8'hFE);
        chk("r2_d0_seg", {1'b0, sevenSeg}, 8'h0E);
        for (int i = 0; i < 2 * DIV + 2; i++) step("post_r2");

        // asynchronous reset in the middle of a clock high phase
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_an", AN, 8'hFF);
        chk("arst_seg", {1'b0, sevenSeg}, 8'h7F);
        @(negedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 8 * DIV + 3; i++) step("post_arst");

        // leading-zero values
        number = 32'h00000042;
        for (int i = 0; i < 8 * DIV; i++) step("lz42");
        number = 32'h0;
        for (int i = 0; i < 8 * DIV; i++) step("lz0");

        // random inputs with occasional restarts
        for (int i = 0; i < 600; i++) begin
            number  = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom >> $urandom_range(0, 31));
            AN_ON   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            reset_2 = ($urandom_range(0, 29) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
